// File: rtl/my_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : my_pkg
//  Purpose  : Shared parser types and the per-word parse step used by the
//             packet parser front-end (parse state, reset value, parse_32)
//             plus the FSM encoding for parse_frame_checksum.
//  Revision : 1.0  initial release
// ============================================================================
package my_pkg;

  // Running parser state carried across the beats of one frame.
  typedef struct packed {
    logic [15:0] working_checksum;
  } parse_state_t;

  // State every frame starts from.
  localparam parse_state_t reset_state = '{working_checksum: 16'h0000};

  // Frame checksum front-end FSM: COLLECT = no result pending, HOLD = result on m_*.
  typedef enum logic {PFC_COLLECT, PFC_HOLD} pfc_fsm_t;

  // One parse step: fold the low half-word into the checksum.
  // Plain modulo-2^16 sum; carries out of bit 15 are dropped, not folded back.
  function automatic parse_state_t parse_32(input logic [31:0] data,
                                            input parse_state_t st);
    parse_state_t w_nxt;
    w_nxt = st;
    w_nxt.working_checksum = st.working_checksum + data[15:0];
    return w_nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parse_frame_checksum.sv
`default_nettype none
// ============================================================================
//  Module   : parse_frame_checksum
//  Purpose  : Stream front-end for the packet parser. Runs parse_32 on every
//             accepted 32-bit beat, and at end of frame presents the final
//             working checksum on a valid/ready result port, then restarts.
//  Options  : CHKSUM_WORD_COUNT_EN - adds WCNT_W parameter and m_words port
//             carrying the (saturating) number of beats in the frame.
//  Revision : 1.0  initial release
// ============================================================================
module parse_frame_checksum
  import my_pkg::*;
`ifdef CHKSUM_WORD_COUNT_EN
#(
  parameter int WCNT_W = 16
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef CHKSUM_WORD_COUNT_EN
  output logic [WCNT_W-1:0] m_words,
`endif
  output logic [15:0]       m_checksum
);

  pfc_fsm_t     r_fsm;
  pfc_fsm_t     w_fsm_nxt;
  parse_state_t r_state;
  parse_state_t w_parsed;
  logic [15:0]  r_m_checksum;
  logic         w_accept;
  logic         w_accept_last;

  // A new beat can enter whenever nothing is pending, or the pending result
  // is being consumed this very cycle.
  assign s_ready       = (r_fsm == PFC_COLLECT) || m_ready;
  assign w_accept      = s_valid && s_ready;
  assign w_accept_last = w_accept && s_last;
  assign w_parsed      = parse_32(s_data, r_state);

  // The result is valid exactly while the FSM holds it.
  assign m_valid    = (r_fsm == PFC_HOLD);
  assign m_checksum = r_m_checksum;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= PFC_COLLECT;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next state: a closing beat always (re)loads the result; otherwise a consumed result frees the port.
  always_comb begin
    w_fsm_nxt = r_fsm;
    if (w_accept_last) begin
      w_fsm_nxt = PFC_HOLD;
    end else if ((r_fsm == PFC_HOLD) && m_ready) begin
      w_fsm_nxt = PFC_COLLECT;
    end
  end

  // Accumulator and result register; the result only changes on a closing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= reset_state;
      r_m_checksum <= 16'h0000;
    end else if (w_accept) begin
      if (s_last) begin
        r_m_checksum <= w_parsed.working_checksum;
        r_state      <= reset_state;
      end else begin
        r_state      <= w_parsed;
      end
    end
  end

`ifdef CHKSUM_WORD_COUNT_EN
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] r_m_words;
  logic [WCNT_W-1:0] w_wcnt_inc;

  // Count including the current beat, pinned at all-ones once full.
  assign w_wcnt_inc = (&r_wcnt) ? r_wcnt : r_wcnt + 1'b1;
  assign m_words    = r_m_words;

  // Per-frame beat counter, captured alongside the checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_m_words <= '0;
    end else if (w_accept) begin
      if (s_last) begin
        r_m_words <= w_wcnt_inc;
        r_wcnt    <= '0;
      end else begin
        r_wcnt    <= w_wcnt_inc;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parse_frame_checksum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parse_frame_checksum
//  Purpose  : Self-checking bench for parse_frame_checksum (table of single-
//             cycle vectors plus hand-written multi-cycle sequences). Build
//             with CHKSUM_WORD_COUNT_EN to also exercise m_words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parse_frame_checksum;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_checksum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef CHKSUM_WORD_COUNT_EN
  logic [15:0] m_words;
  logic        s2_valid, s2_ready, s2_last, m2_valid, m2_ready;
  logic [31:0] s2_data;
  logic [15:0] m2_checksum;
  logic [1:0]  m2_words;

  parse_frame_checksum #(.WCNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_words(m_words),
    .m_checksum(m_checksum));

  parse_frame_checksum #(.WCNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
    .s_last(s2_last), .m_valid(m2_valid), .m_ready(m2_ready), .m_words(m2_words),
    .m_checksum(m2_checksum));
`else
  parse_frame_checksum u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_checksum(m_checksum));
`endif

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic        exp_sr;   // s_ready before the edge
    logic        exp_mv;   // m_valid after the edge
    logic [15:0] exp_chk;  // m_checksum after the edge (when exp_mv)
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic mr,
                              logic sr, logic mv, logic [15:0] chk);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.mr = mr; r.exp_sr = sr; r.exp_mv = mv; r.exp_chk = chk;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic mr);
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef CHKSUM_WORD_COUNT_EN
    s2_valid = 1'b0; s2_data = 32'h0; s2_last = 1'b0; m2_ready = 1'b1;
`endif
    cycle(); cycle();
    rst = 1'b0;
    #1;
    check("reset_m_valid", {31'b0, m_valid}, 32'h0);
    check("reset_m_checksum", {16'b0, m_checksum}, 32'h0);
    check("reset_s_ready", {31'b0, s_ready}, 32'h1);

    //            v     data          last  mr    sr    mv    chk
    tbl[0]  = mk(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 32'h1234_0002, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b1, 32'hFFFF_0003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0006);
    tbl[3]  = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[4]  = mk(1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[5]  = mk(1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001);
    tbl[6]  = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[7]  = mk(1'b1, 32'h0000_AAAA, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA);
    tbl[8]  = mk(1'b1, 32'h0000_5555, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
    tbl[9]  = mk(1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001);
    tbl[10] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[11] = mk(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[12] = mk(1'b0, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[13] = mk(1'b1, 32'h0000_0023, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0123);
    tbl[14] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
    tbl[15] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
      #1;
      check($sformatf("tbl%0d_s_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].exp_sr});
      cycle();
      check($sformatf("tbl%0d_m_valid", i), {31'b0, m_valid}, {31'b0, tbl[i].exp_mv});
      if (tbl[i].exp_mv)
        check($sformatf("tbl%0d_m_checksum", i), {16'b0, m_checksum}, {16'b0, tbl[i].exp_chk});
    end

    // Back-pressure: result 0x0042 held while the next frame waits.
    drive(1'b1, 32'h0000_0042, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_s_ready", k), {31'b0, s_ready}, 32'h0);
      check($sformatf("bp%0d_m_valid", k), {31'b0, m_valid}, 32'h1);
      check($sformatf("bp%0d_m_checksum", k), {16'b0, m_checksum}, 32'h0042);
      cycle();
    end
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b1);
    #1;
    check("bp_release_s_ready", {31'b0, s_ready}, 32'h1);
    cycle();
    check("bp_release_m_valid", {31'b0, m_valid}, 32'h0);
    drive(1'b1, 32'h0000_0006, 1'b1, 1'b1);
    cycle();
    check("bp_next_m_valid", {31'b0, m_valid}, 32'h1);
    check("bp_next_m_checksum", {16'b0, m_checksum}, 32'h000B);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    cycle();

    // Mid-frame reset discards the partial frame.
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b1);
    cycle(); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_mid_m_valid", {31'b0, m_valid}, 32'h0);
    check("rst_mid_s_ready", {31'b0, s_ready}, 32'h1);
    drive(1'b1, 32'h0000_0007, 1'b1, 1'b1);
    cycle();
    check("rst_mid_m_valid_after", {31'b0, m_valid}, 32'h1);
    check("rst_mid_m_checksum", {16'b0, m_checksum}, 32'h0007);

    // Reset while a result is held clears it.
    drive(1'b1, 32'h0000_0099, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_hold_m_valid", {31'b0, m_valid}, 32'h0);
    check("rst_hold_m_checksum", {16'b0, m_checksum}, 32'h0);
    check("rst_hold_s_ready", {31'b0, s_ready}, 32'h1);

`ifdef CHKSUM_WORD_COUNT_EN
    // Word count: 3-beat frame on the wide counter, 5-beat frame saturating a 2-bit one.
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    s2_valid = 1'b1; s2_data = 32'h0000_0001; s2_last = 1'b0;
    cycle();
    drive(1'b1, 32'h1234_0002, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'hFFFF_0003, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("wc_m_checksum", {16'b0, m_checksum}, 32'h0006);
    check("wc_m_words", {16'b0, m_words}, 32'h3);
    cycle();
    s2_last = 1'b1;
    cycle();
    s2_valid = 1'b0; s2_last = 1'b0;
    check("wc2_m_valid", {31'b0, m2_valid}, 32'h1);
    check("wc2_m_checksum", {16'b0, m2_checksum}, 32'h0005);
    check("wc2_m_words", {30'b0, m2_words}, 32'h3);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
